// File: rtl/pipe_scheduler.sv
// pipe_scheduler
//   Game-state machine and obstacle stream for Flappy Block. Once per frame
//   tick while running, scrolls every active pipe slot left by SPEED pixels,
//   retires pipes that reach the left edge, flags a score when a pipe crosses
//   BIRD_X, and spawns a new pipe every SPAWN_FRAMES ticks with its gap
//   height taken (clamped) from the external LFSR. Also pulses the LFSR
//   reseed on each IDLE->RUN transition.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   frame_tick   one-cycle pulse per video frame
//   start        start / restart request (meaning depends on state)
//   collide      collision reported by the collision logic
//   rand_in      10-bit random value from the LFSR
//   rng_rst      one-cycle reseed pulse to the LFSR
//   state        00 IDLE, 01 RUN, 10 HALT
//   pipe_valid   per-slot occupied flags
//   pipe_x       per-slot left-edge x, slot i at [10i+9:10i]
//   pipe_gap     per-slot gap height, same packing as pipe_x
//   score_pulse  one-cycle pulse when a pipe crosses BIRD_X
module pipe_scheduler #(
    parameter int NPIPES       = 4,
    parameter int SCREEN_W     = 640,
    parameter int SPEED        = 2,
    parameter int SPAWN_FRAMES = 90,
    parameter int BIRD_X       = 160,
    parameter int GAP_MIN      = 20,
    parameter int GAP_MAX      = 147
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic                     start,
    input  logic                     collide,
    input  logic [9:0]               rand_in,
    output logic                     rng_rst,
    output logic [1:0]               state,
    output logic [NPIPES-1:0]        pipe_valid,
    output logic [NPIPES*10-1:0]     pipe_x,
    output logic [NPIPES*10-1:0]     pipe_gap,
    output logic                     score_pulse
);

    localparam int CW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SPAWN_FRAMES - 1);
    localparam logic [9:0] SCREEN_C  = 10'(SCREEN_W);
    localparam logic [9:0] SPEED_C   = 10'(SPEED);
    localparam logic [9:0] BIRD_C    = 10'(BIRD_X);
    localparam logic [9:0] GAP_MIN_C = 10'(GAP_MIN);
    localparam logic [9:0] GAP_MAX_C = 10'(GAP_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    state_t            state_reg, state_next;
    logic [NPIPES-1:0] valid_reg, valid_next;
    logic [9:0]        x_reg    [NPIPES];
    logic [9:0]        x_next   [NPIPES];
    logic [9:0]        gap_reg  [NPIPES];
    logic [9:0]        gap_next [NPIPES];
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              rng_rst_reg, rng_rst_next;
    logic              score_reg, score_next;

    logic [9:0]        gap_clamped;
    logic              spawn_due;
    logic              placed;

    assign gap_clamped = (rand_in < GAP_MIN_C) ? GAP_MIN_C :
                         (rand_in > GAP_MAX_C) ? GAP_MAX_C : rand_in;
    assign spawn_due   = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next   = state_reg;
        valid_next   = valid_reg;
        cnt_next     = cnt_reg;
        rng_rst_next = 1'b0;
        score_next   = 1'b0;
        placed       = 1'b0;
        for (int i = 0; i < NPIPES; i++) begin
            x_next[i]   = x_reg[i];
            gap_next[i] = gap_reg[i];
        end

        case (state_reg)
            S_IDLE: begin
                valid_next = '0;
                // Preload so the very first tick in RUN spawns a pipe.
                cnt_next   = CNT_LAST;
                if (start) begin
                    state_next   = S_RUN;
                    rng_rst_next = 1'b1;
                end
            end

            S_RUN: begin
                if (collide) begin
                    // Collision wins over a same-cycle tick: freeze everything.
                    state_next = S_HALT;
                end else if (frame_tick) begin
                    // Move / retire existing pipes from the pre-tick state.
                    for (int i = 0; i < NPIPES; i++) begin
                        if (valid_reg[i]) begin
                            if (x_reg[i] >= SPEED_C) begin
                                x_next[i] = x_reg[i] - SPEED_C;
                                if ((x_reg[i] >= BIRD_C) && ((x_reg[i] - SPEED_C) < BIRD_C))
                                    score_next = 1'b1;
                            end else begin
                                valid_next[i] = 1'b0;
                            end
                        end
                    end

                    cnt_next = spawn_due ? '0 : cnt_reg + 1'b1;

                    // Spawn into the lowest free slot after retirement; the
                    // new pipe is not moved this tick. Dropped if none free.
                    if (spawn_due) begin
                        for (int i = 0; i < NPIPES; i++) begin
                            if (!placed && !valid_next[i]) begin
                                valid_next[i] = 1'b1;
                                x_next[i]     = SCREEN_C;
                                gap_next[i]   = gap_clamped;
                                placed        = 1'b1;
                            end
                        end
                    end
                end
            end

            S_HALT: begin
                if (start) begin
                    state_next = S_IDLE;
                    valid_next = '0;
                end
            end

            default: begin
                state_next = S_IDLE;
                valid_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            valid_reg   <= '0;
            cnt_reg     <= '0;
            rng_rst_reg <= 1'b0;
            score_reg   <= 1'b0;
            for (int i = 0; i < NPIPES; i++) begin
                x_reg[i]   <= '0;
                gap_reg[i] <= '0;
            end
        end else begin
            state_reg   <= state_next;
            valid_reg   <= valid_next;
            cnt_reg     <= cnt_next;
            rng_rst_reg <= rng_rst_next;
            score_reg   <= score_next;
            for (int i = 0; i < NPIPES; i++) begin
                x_reg[i]   <= x_next[i];
                gap_reg[i] <= gap_next[i];
            end
        end
    end

    assign state       = state_reg;
    assign pipe_valid  = valid_reg;
    assign rng_rst     = rng_rst_reg;
    assign score_pulse = score_reg;

    for (genvar gi = 0; gi < NPIPES; gi++) begin : g_pack
        assign pipe_x[gi*10 +: 10]   = x_reg[gi];
        assign pipe_gap[gi*10 +: 10] = gap_reg[gi];
    end

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler
//   Self-checking bench for pipe_scheduler. A default-parameter instance is
//   driven by a vector table and a scroll sequence through a scoreboard; a
//   small instance (2 slots, 10-frame spawn interval) covers spawn cadence
//   and dropped spawns.
module tb_pipe_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        tick = 0, start = 0, collide = 0;
    logic [9:0]  rand_v = '0;
    logic        rng_rst, score_pulse;
    logic [1:0]  state;
    logic [3:0]  pipe_valid;
    logic [39:0] pipe_x, pipe_gap;

    pipe_scheduler dut (
        .clk(clk), .rst(rst), .frame_tick(tick), .start(start), .collide(collide),
        .rand_in(rand_v), .rng_rst(rng_rst), .state(state), .pipe_valid(pipe_valid),
        .pipe_x(pipe_x), .pipe_gap(pipe_gap), .score_pulse(score_pulse)
    );

    // Small instance
    logic        tick_s = 0, start_s = 0, collide_s = 0;
    logic [9:0]  rand_s = 10'd50;
    logic        rng_rst_s, score_s;
    logic [1:0]  state_s;
    logic [1:0]  valid_s;
    logic [19:0] x_s, gap_s;

    pipe_scheduler #(.NPIPES(2), .SPAWN_FRAMES(10)) dut_s (
        .clk(clk), .rst(rst), .frame_tick(tick_s), .start(start_s), .collide(collide_s),
        .rand_in(rand_s), .rng_rst(rng_rst_s), .state(state_s), .pipe_valid(valid_s),
        .pipe_x(x_s), .pipe_gap(gap_s), .score_pulse(score_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       chk_valid;
        logic [3:0] valid;
        logic       chk_x;
        logic [9:0] x0;
        logic       chk_gap;
        logic [9:0] gap0;
        logic       score;
        logic       rng;
    } exp_t;

    typedef struct {
        logic       t, s, c;
        logic [9:0] r;
        logic [1:0] st;
        logic [3:0] valid;
        logic       cx;
        logic [9:0] x0;
        logic       cg;
        logic [9:0] g0;
        logic       rng;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    function automatic vec_t mkv(input logic t, input logic s, input logic c, input int r,
                                 input logic [1:0] st, input logic [3:0] v,
                                 input logic cx, input int x0, input logic cg, input int g0,
                                 input logic rng);
        vec_t o;
        o.t = t; o.s = s; o.c = c; o.r = 10'(r);
        o.st = st; o.valid = v; o.cx = cx; o.x0 = 10'(x0); o.cg = cg; o.g0 = 10'(g0);
        o.rng = rng;
        return o;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".state"}, 64'(state), 64'(e.st));
        chk({e.tag, ".rng_rst"}, 64'(rng_rst), 64'(e.rng));
        chk({e.tag, ".score"}, 64'(score_pulse), 64'(e.score));
        if (e.chk_valid) chk({e.tag, ".valid"}, 64'(pipe_valid), 64'(e.valid));
        if (e.chk_x)     chk({e.tag, ".x0"}, 64'(pipe_x[9:0]), 64'(e.x0));
        if (e.chk_gap)   chk({e.tag, ".gap0"}, 64'(pipe_gap[9:0]), 64'(e.gap0));
    endtask

    task automatic step(input logic t, input logic s, input logic c, input logic [9:0] r,
                        input exp_t e);
        tick = t; start = s; collide = c; rand_v = r;
        sb.push_back(e);
        @(posedge clk); #1;
        tick = 0; start = 0; collide = 0;
        check_out();
    endtask

    initial begin
        exp_t e;
        vec_t v;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset.state", 64'(state), 0);
        chk("reset.valid", 64'(pipe_valid), 0);
        chk("reset.x", 64'(pipe_x), 0);
        chk("reset.gap", 64'(pipe_gap), 0);
        chk("reset.rng", 64'(rng_rst), 0);
        chk("reset.score", 64'(score_pulse), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle.state", 64'(state), 0);
        chk("idle.valid", 64'(pipe_valid), 0);

        // t  s  c  rand  state  valid cx x0  cg gap rng
        vecs.push_back(mkv(0, 1, 0, 0,    2'b01, 4'b0000, 0, 0,   0, 0,   1)); // start, reseed
        vecs.push_back(mkv(0, 0, 0, 0,    2'b01, 4'b0000, 0, 0,   0, 0,   0)); // reseed one cycle only
        vecs.push_back(mkv(1, 0, 0, 5,    2'b01, 4'b0001, 1, 640, 1, 20,  0)); // first tick spawns, clamp low
        vecs.push_back(mkv(1, 0, 0, 600,  2'b01, 4'b0001, 1, 638, 1, 20,  0)); // move, no spawn
        vecs.push_back(mkv(1, 1, 1, 0,    2'b10, 4'b0001, 1, 638, 1, 20,  0)); // collide beats tick
        vecs.push_back(mkv(1, 0, 0, 0,    2'b10, 4'b0001, 1, 638, 1, 20,  0)); // halted, tick ignored
        vecs.push_back(mkv(0, 1, 0, 0,    2'b00, 4'b0000, 0, 0,   0, 0,   0)); // halt->idle, no reseed
        vecs.push_back(mkv(0, 1, 0, 0,    2'b01, 4'b0000, 0, 0,   0, 0,   1)); // idle->run reseeds
        vecs.push_back(mkv(1, 0, 0, 600,  2'b01, 4'b0001, 1, 640, 1, 147, 0)); // clamp high
        vecs.push_back(mkv(0, 0, 1, 0,    2'b10, 4'b0001, 1, 640, 1, 147, 0));
        vecs.push_back(mkv(0, 1, 0, 0,    2'b00, 4'b0000, 0, 0,   0, 0,   0));
        vecs.push_back(mkv(0, 1, 0, 0,    2'b01, 4'b0000, 0, 0,   0, 0,   1));
        vecs.push_back(mkv(1, 0, 0, 100,  2'b01, 4'b0001, 1, 640, 1, 100, 0)); // in range
        vecs.push_back(mkv(1, 1, 0, 5,    2'b01, 4'b0001, 1, 638, 1, 100, 0)); // start ignored in RUN
        vecs.push_back(mkv(0, 0, 1, 0,    2'b10, 4'b0001, 1, 638, 1, 100, 0));
        vecs.push_back(mkv(0, 1, 0, 0,    2'b00, 4'b0000, 0, 0,   0, 0,   0));
        vecs.push_back(mkv(0, 1, 0, 0,    2'b01, 4'b0000, 0, 0,   0, 0,   1));
        vecs.push_back(mkv(1, 0, 0, 147,  2'b01, 4'b0001, 1, 640, 1, 147, 0)); // clamp edge value

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            e.tag = $sformatf("vec%0d", i);
            e.st = v.st; e.chk_valid = 1'b1; e.valid = v.valid;
            e.chk_x = v.cx; e.x0 = v.x0; e.chk_gap = v.cg; e.gap0 = v.g0;
            e.score = 1'b0; e.rng = v.rng;
            step(v.t, v.s, v.c, v.r, e);
            $display("vec%0d: state=%0d valid=%b x0=%0d gap0=%0d rng=%0d",
                     i, state, pipe_valid, pipe_x[9:0], pipe_gap[9:0], rng_rst);
        end

        // Scroll / score / retire of slot 0 (spawned by the last vector)
        for (int k = 1; k <= 321; k++) begin
            e.tag = $sformatf("scroll%0d", k);
            e.st = 2'b01; e.chk_valid = 1'b0; e.valid = '0;
            e.chk_x = (k <= 320); e.x0 = 10'(640 - 2 * k);
            e.chk_gap = 1'b1; e.gap0 = 10'd147;
            e.score = (k == 241); e.rng = 1'b0;
            step(1'b1, 1'b0, 1'b0, 10'd60, e);
            if (k == 240 || k == 241 || k >= 320)
                $display("scroll tick %0d: x0=%0d valid=%b score=%0d",
                         k, pipe_x[9:0], pipe_valid, score_pulse);
            if (k == 320) chk("scroll320.valid0", 64'(pipe_valid[0]), 1);
            if (k == 321) chk("scroll321.valid0", 64'(pipe_valid[0]), 0);
        end
        chk("scroll.three_active", 64'(pipe_valid), 64'(4'b1110));

        // Asynchronous reset between edges
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        $display("async reset: state=%0d valid=%b", state, pipe_valid);
        chk("arst.state", 64'(state), 0);
        chk("arst.valid", 64'(pipe_valid), 0);
        chk("arst.x", 64'(pipe_x), 0);
        chk("arst.gap", 64'(pipe_gap), 0);
        chk("arst.score", 64'(score_pulse), 0);
        chk("arst.rng", 64'(rng_rst), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Spawn cadence on the 2-slot, 10-frame instance
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        chk("small.start.state", 64'(state_s), 1);
        chk("small.start.rng", 64'(rng_rst_s), 1);
        tick_s = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            $display("small tick %0d: valid=%b x0=%0d x1=%0d", t, valid_s, x_s[9:0], x_s[19:10]);
            chk($sformatf("small%0d.valid", t), 64'(valid_s), (t < 11) ? 64'd1 : 64'd3);
            if (t == 1) chk("small1.x0", 64'(x_s[9:0]), 640);
            if (t == 10) chk("small10.x0", 64'(x_s[9:0]), 622);
            if (t == 11) chk("small11.x1", 64'(x_s[19:10]), 640);
            if (t == 21 || t == 31 || t == 40) begin
                chk($sformatf("small%0d.x0", t), 64'(x_s[9:0]), 64'(640 - 2 * (t - 1)));
                chk($sformatf("small%0d.x1", t), 64'(x_s[19:10]), 64'(640 - 2 * (t - 11)));
            end
        end
        tick_s = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_scheduler.md
# pipe_scheduler

Controls the Flappy Block obstacle stream. Runs a small game-state machine and, once per video frame, scrolls up to NPIPES active pipe slots leftward, retires pipes that reach the left edge, and spawns a new pipe at a fixed frame interval. Each new pipe's gap height is sampled from the free-running LFSR random source, and this block also re-seeds that source at game start. Sits between the frame-timing logic and the renderer/collision logic.

## Interface
- NPIPES, 4: number of pipe slots
- SCREEN_W, 640: spawn x coordinate (left edge of new pipe)
- SPEED, 2: pixels moved per frame tick
- SPAWN_FRAMES, 90: frame ticks between spawn attempts
- BIRD_X, 160: x coordinate whose crossing scores a point
- GAP_MIN, 20 / GAP_MAX, 147: clamp range for gap height
- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per frame
- start  in  1  level or pulse; its meaning depends on state
- collide  in  1  collision reported by collision logic
- rand_in  in  10  random value from the LFSR block
- rng_rst  out  1  one-cycle reseed pulse to the LFSR block
- state  out  2  00 IDLE, 01 RUN, 10 HALT
- pipe_valid  out  NPIPES  slot-occupied flags
- pipe_x  out  NPIPES*10  per-slot left-edge x; slot i is at bits [10i+9:10i]
- pipe_gap  out  NPIPES*10  per-slot gap height, same packing as pipe_x
- score_pulse  out  1  one-cycle pulse when a pipe crosses BIRD_X

## Operation
- **Reset (rst=0):** asynchronous. state=IDLE; pipe_valid, pipe_x, pipe_gap, rng_rst, score_pulse and the spawn counter all go to 0.
- **IDLE:**
  - All slots are invalid.
  - start=1 → RUN, with rng_rst=1 for exactly that one cycle.
  - Spawn counter is preloaded to SPAWN_FRAMES-1, so the first tick in RUN spawns a pipe.
- **RUN:** on each cycle with frame_tick=1, in this order:
  - **Move:** each valid slot with x ≥ SPEED gets x ← x − SPEED. A valid slot with x < SPEED is cleared (valid ← 0; x and gap hold their stale values).
  - **Score:** score_pulse=1 if any slot moved with old x ≥ BIRD_X and new x < BIRD_X. At most one pulse per tick, even if several slots cross.
  - **Spawn:**
    - If counter == SPAWN_FRAMES-1, the counter goes to 0; otherwise it increments.
    - On a spawn tick, the lowest-index free slot (including one freed by this tick's retire) gets valid=1, x=SCREEN_W, gap=clamp(rand_in, GAP_MIN, GAP_MAX).
    - A newly spawned pipe does not move on its spawn tick.
    - If no slot is free, the spawn is dropped and the counter still wraps to 0.
- **RUN, collide=1:**
  - → HALT on that edge.
  - Collide takes priority over a simultaneous frame_tick: no move, spawn or score that cycle.
  - start is ignored while in RUN.
- **HALT:**
  - All slots and the counter are frozen.
  - frame_tick is ignored.
  - start=1 → IDLE, clearing all pipe_valid bits.
  - A start from HALT does not pulse rng_rst; the next IDLE→RUN transition does.
- **Arithmetic:** all coordinates are 10-bit unsigned. The clamp compares the full 10-bit rand_in value.

## Timing
- All registered outputs update on the rising edge of clk in which frame_tick, start or collide is sampled. Latency is 1 cycle from input to visible output.
- score_pulse and rng_rst are registered single-cycle pulses and are 0 on every other cycle.
- rand_in is sampled only on the spawn edge; no handshake with the LFSR is required.
- rst deasserting while frame_tick=1 performs no update on that edge.
- Asserting rst mid-game returns everything to the reset values immediately, with no clock needed.
- frame_tick pulses closer than 1 cycle apart are not supported. Back-to-back ticks on consecutive cycles are each processed fully.

## Test plan
- **Reset then start:** rst low, release, start=1 for one cycle → state=01, rng_rst high for exactly 1 cycle. On the first tick: slot0 valid, x=640, gap=clamp(rand_in).
- **Clamp:** rand_in=5 at spawn → gap=20; rand_in=600 → gap=147; rand_in=100 → gap=100.
- **Scroll, score and retire (SPEED=2):** after spawn, 240 ticks → x=160 with no score. Tick 241 → x=158 and score_pulse=1. Tick 320 → x=0, still valid. Tick 321 → slot0 invalid.
- **Spawn cadence and full slots:** NPIPES=2, SPAWN_FRAMES=10, run 40 ticks → spawns land only on ticks 1, 11, 21, 31. The spawns on ticks 21 and 31 are dropped while both slots are busy, and pipe_valid never exceeds 2'b11.
- **Collide with tick, then restart:** collide=1 and frame_tick=1 on the same edge → state=10 and all x values unchanged. Further ticks produce no change. start → IDLE with pipe_valid=0. start again → RUN with an rng_rst pulse.
- **Async reset mid-RUN:** drop rst between clock edges with 3 pipes active → all outputs 0 and state=00 before the next edge.
